fiqsha_apb_adapter: RTL and testbench

FIQSHA_APB_ADAPTER -- requirements
Module: fiqsha_apb_adapter

---
 rtl/fiqsha_apb_adapter_if.sv | 44 ++++
 rtl/fiqsha_apb_adapter.sv | 132 +++++++++++++
 tb/tb_fiqsha_apb_adapter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fiqsha_apb_adapter_if.sv
// Bus bundle between the APB master, the adapter and the SHA interface control logic.
// Signal suffixes follow the adapter's point of view; the slave modport is the adapter side.
interface fiqsha_apb_adapter_if #(
  parameter int BUS_DATA_WIDTH = 32
);
  localparam int STRB_W = BUS_DATA_WIDTH / 8;

  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [11:0]               paddr_i;
  logic [BUS_DATA_WIDTH-1:0] pwdata_i;
  logic [STRB_W-1:0]         pstrb_i;
  logic                      pready_o;
  logic [BUS_DATA_WIDTH-1:0] prdata_o;
  logic                      pslverr_o;

  logic                      wr_o;
  logic                      wr_ack_i;
  logic                      slv_error_i;
  logic [11:0]               waddr_o;
  logic [11:0]               raddr_o;
  logic [BUS_DATA_WIDTH-1:0] wdata_o;
  logic [STRB_W-1:0]         wbyte_enable_o;
  logic                      rd_o;
  logic                      rd_ack_o;
  logic [BUS_DATA_WIDTH-1:0] rdata_i;
  logic                      read_valid_i;
  logic [1:0]                burst_type_o;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    input  wr_ack_i, slv_error_i, rdata_i, read_valid_i,
    output pready_o, prdata_o, pslverr_o,
    output wr_o, waddr_o, raddr_o, wdata_o, wbyte_enable_o, rd_o, rd_ack_o, burst_type_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
    output wr_ack_i, slv_error_i, rdata_i, read_valid_i,
    input  pready_o, prdata_o, pslverr_o,
    input  wr_o, waddr_o, raddr_o, wdata_o, wbyte_enable_o, rd_o, rd_ack_o, burst_type_o
  );
endinterface

// File: rtl/fiqsha_apb_adapter.sv
// APB slave to SHA native read/write request adapter, one transfer at a time.
// Define FIQSHA_APB_TIMEOUT_EN to bound WRITE/READ waits to TIMEOUT_CYCLES (error on expiry).
module fiqsha_apb_adapter #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fiqsha_apb_adapter_if.slave  bus
);
  localparam int STRB_W = BUS_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                    state_q, state_d;
  logic [11:0]               addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         strb_q, strb_d;
  logic [BUS_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      error_q, error_d;
  logic                      rd_first_q, rd_first_d;
  logic                      rd_ack_q, rd_ack_d;
  logic                      timeout;

`ifdef FIQSHA_APB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counter is held at zero in IDLE, so it starts from zero on every WRITE/READ entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)
      cnt_d = 8'd0;
    else if (state_q == WRITE || state_q == READ)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    rd_first_d = rd_first_q;
    rd_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.psel_i && !bus.penable_i) begin
          addr_d     = bus.paddr_i;
          wdata_d    = bus.pwdata_i;
          strb_d     = bus.pstrb_i;
          error_d    = 1'b0;
          rd_first_d = !bus.pwrite_i;
          state_d    = bus.pwrite_i ? WRITE : READ;
        end
      end
      WRITE: begin
        // Abort wins; a simultaneous ack and error reports the error.
        if (!bus.psel_i) begin
          state_d = IDLE;
        end else if (bus.slv_error_i || timeout) begin
          error_d = 1'b1;
          state_d = DONE;
        end else if (bus.wr_ack_i) begin
          error_d = 1'b0;
          state_d = DONE;
        end
      end
      READ: begin
        rd_first_d = 1'b0;
        if (!bus.psel_i) begin
          state_d = IDLE;
        end else if (bus.read_valid_i) begin
          rdata_d  = bus.rdata_i;
          rd_ack_d = 1'b1;
          error_d  = 1'b0;
          state_d  = DONE;
        end else if (timeout) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
      rd_first_q <= 1'b0;
      rd_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
      rd_first_q <= rd_first_d;
      rd_ack_q   <= rd_ack_d;
    end
  end

  // Requests drop in the same cycle the master releases psel.
  assign bus.wr_o           = (state_q == WRITE) && bus.psel_i;
  assign bus.rd_o           = (state_q == READ) && rd_first_q && bus.psel_i;
  assign bus.rd_ack_o       = rd_ack_q;
  assign bus.pready_o       = (state_q == DONE);
  assign bus.pslverr_o      = (state_q == DONE) && error_q;
  assign bus.prdata_o       = rdata_q;
  assign bus.waddr_o        = addr_q;
  assign bus.raddr_o        = addr_q;
  assign bus.wdata_o        = wdata_q;
  assign bus.wbyte_enable_o = strb_q;
  assign bus.burst_type_o   = 2'b00;
endmodule

// File: tb/tb_fiqsha_apb_adapter.sv
// Directed bench for fiqsha_apb_adapter: inputs change and outputs are sampled on the falling edge.
module tb_fiqsha_apb_adapter;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  fiqsha_apb_adapter_if #(.BUS_DATA_WIDTH(32)) bus ();

  fiqsha_apb_adapter #(.BUS_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pwrite_i = 1'b0;
    bus.paddr_i = 12'h0; bus.pwdata_i = 32'h0; bus.pstrb_i = 4'h0;
    bus.wr_ack_i = 1'b0; bus.slv_error_i = 1'b0;
    bus.rdata_i = 32'h0; bus.read_valid_i = 1'b0;
  endtask

  task automatic drive_setup(input logic wr, input logic [11:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    bus.psel_i = 1'b1; bus.penable_i = 1'b0; bus.pwrite_i = wr;
    bus.paddr_i = addr; bus.pwdata_i = data; bus.pstrb_i = strb;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_tests++; if ({bus.pready_o, bus.pslverr_o, bus.wr_o, bus.rd_o, bus.rd_ack_o} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b exp 00000", {bus.pready_o, bus.pslverr_o, bus.wr_o, bus.rd_o, bus.rd_ack_o}); end
    n_tests++; if (bus.prdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_prdata: got %h exp 0", bus.prdata_o); end
    n_tests++; if ({bus.waddr_o, bus.raddr_o, bus.wdata_o, bus.wbyte_enable_o, bus.burst_type_o} !== 62'h0) begin n_fail++; $display("FAIL rst_native: got %h exp 0", {bus.waddr_o, bus.raddr_o, bus.wdata_o, bus.wbyte_enable_o, bus.burst_type_o}); end
    rst = 1'b0;
  endtask

  // Setup driven in the same half-cycle as reset release: first rising edge must capture it.
  task automatic test_write_ack;
    drive_setup(1'b1, 12'h020, 32'h1, 4'hF);
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if (bus.wr_o !== 1'b1) begin n_fail++; $display("FAIL wa_wr_c1: got %b exp 1", bus.wr_o); end
    n_tests++; if (bus.waddr_o !== 12'h020) begin n_fail++; $display("FAIL wa_waddr: got %h exp 020", bus.waddr_o); end
    n_tests++; if (bus.wdata_o !== 32'h1) begin n_fail++; $display("FAIL wa_wdata: got %h exp 1", bus.wdata_o); end
    n_tests++; if (bus.wbyte_enable_o !== 4'hF) begin n_fail++; $display("FAIL wa_strb: got %h exp f", bus.wbyte_enable_o); end
    n_tests++; if (bus.pready_o !== 1'b0) begin n_fail++; $display("FAIL wa_pready_c1: got %b exp 0", bus.pready_o); end
    @(negedge clk);
    n_tests++; if ({bus.wr_o, bus.pready_o} !== 2'b10) begin n_fail++; $display("FAIL wa_c2: got wr,pready=%b exp 10", {bus.wr_o, bus.pready_o}); end
    bus.wr_ack_i = 1'b1;
    @(negedge clk); bus.wr_ack_i = 1'b0;
    n_tests++; if ({bus.pready_o, bus.pslverr_o, bus.wr_o} !== 3'b100) begin n_fail++; $display("FAIL wa_c3: got pready,pslverr,wr=%b exp 100", {bus.pready_o, bus.pslverr_o, bus.wr_o}); end
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.pready_o !== 1'b0) begin n_fail++; $display("FAIL wa_c4_pready: got %b exp 0", bus.pready_o); end
  endtask

  task automatic test_write_error;
    int wr_cnt = 0;
    @(negedge clk); drive_setup(1'b1, 12'h140, 32'hDEAD_BEEF, 4'h3);
    @(negedge clk); bus.penable_i = 1'b1; if (bus.wr_o) wr_cnt++;
    @(negedge clk); if (bus.wr_o) wr_cnt++; bus.slv_error_i = 1'b1;
    @(negedge clk); if (bus.wr_o) wr_cnt++; bus.slv_error_i = 1'b0;
    n_tests++; if ({bus.pready_o, bus.pslverr_o} !== 2'b11) begin n_fail++; $display("FAIL we_done: got pready,pslverr=%b exp 11", {bus.pready_o, bus.pslverr_o}); end
    drive_idle();
    @(negedge clk); if (bus.wr_o) wr_cnt++;
    n_tests++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL we_wr_len: got %0d exp 2", wr_cnt); end
    n_tests++; if (bus.pslverr_o !== 1'b0) begin n_fail++; $display("FAIL we_pslverr_idle: got %b exp 0", bus.pslverr_o); end
    n_tests++; if ({bus.waddr_o, bus.wbyte_enable_o} !== {12'h140, 4'h3}) begin n_fail++; $display("FAIL we_hold: got %h exp 1403", {bus.waddr_o, bus.wbyte_enable_o}); end
    n_tests++; if (bus.prdata_o !== 32'h0) begin n_fail++; $display("FAIL we_prdata: got %h exp 0", bus.prdata_o); end
  endtask

  task automatic test_read;
    @(negedge clk); drive_setup(1'b0, 12'h030, 32'h0, 4'h0);
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if ({bus.rd_o, bus.rd_ack_o} !== 2'b10) begin n_fail++; $display("FAIL rd_c1: got rd,rd_ack=%b exp 10", {bus.rd_o, bus.rd_ack_o}); end
    n_tests++; if (bus.raddr_o !== 12'h030) begin n_fail++; $display("FAIL rd_raddr: got %h exp 030", bus.raddr_o); end
    @(negedge clk);
    n_tests++; if (bus.rd_o !== 1'b0) begin n_fail++; $display("FAIL rd_c2_rd: got %b exp 0", bus.rd_o); end
    bus.read_valid_i = 1'b1; bus.rdata_i = 32'h12;
    @(negedge clk); bus.read_valid_i = 1'b0; bus.rdata_i = 32'h0;
    n_tests++; if ({bus.rd_ack_o, bus.pready_o, bus.pslverr_o} !== 3'b110) begin n_fail++; $display("FAIL rd_c3: got rd_ack,pready,pslverr=%b exp 110", {bus.rd_ack_o, bus.pready_o, bus.pslverr_o}); end
    n_tests++; if (bus.prdata_o !== 32'h12) begin n_fail++; $display("FAIL rd_prdata: got %h exp 12", bus.prdata_o); end
    drive_idle();
    @(negedge clk);
    n_tests++; if ({bus.rd_ack_o, bus.pready_o} !== 2'b00) begin n_fail++; $display("FAIL rd_c4: got rd_ack,pready=%b exp 00", {bus.rd_ack_o, bus.pready_o}); end
    n_tests++; if (bus.prdata_o !== 32'h12) begin n_fail++; $display("FAIL rd_prdata_hold: got %h exp 12", bus.prdata_o); end
  endtask

  task automatic test_timeout;
`ifdef FIQSHA_APB_TIMEOUT_EN
    @(negedge clk); drive_setup(1'b1, 12'h0FC, 32'h77, 4'hF);
    @(negedge clk); bus.penable_i = 1'b1;
    repeat (15) @(negedge clk);
    n_tests++; if ({bus.wr_o, bus.pready_o} !== 2'b10) begin n_fail++; $display("FAIL to_c16: got wr,pready=%b exp 10", {bus.wr_o, bus.pready_o}); end
    @(negedge clk);
    n_tests++; if ({bus.pready_o, bus.pslverr_o, bus.wr_o} !== 3'b110) begin n_fail++; $display("FAIL to_c17: got pready,pslverr,wr=%b exp 110", {bus.pready_o, bus.pslverr_o, bus.wr_o}); end
    n_tests++; if (bus.prdata_o !== 32'h12) begin n_fail++; $display("FAIL to_prdata: got %h exp 12", bus.prdata_o); end
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.pready_o !== 1'b0) begin n_fail++; $display("FAIL to_idle: got %b exp 0", bus.pready_o); end
`else
    int pr_seen = 0;
    @(negedge clk); drive_setup(1'b1, 12'h0FC, 32'h77, 4'hF);
    @(negedge clk); bus.penable_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.pready_o) pr_seen++;
    end
    n_tests++; if (pr_seen !== 0) begin n_fail++; $display("FAIL nto_pready: got %0d cycles exp 0", pr_seen); end
    n_tests++; if (bus.wr_o !== 1'b1) begin n_fail++; $display("FAIL nto_wr: got %b exp 1", bus.wr_o); end
    drive_idle();
    #1;
    n_tests++; if (bus.wr_o !== 1'b0) begin n_fail++; $display("FAIL nto_abort_wr: got %b exp 0", bus.wr_o); end
    @(negedge clk);
    n_tests++; if (bus.pready_o !== 1'b0) begin n_fail++; $display("FAIL nto_abort_pready: got %b exp 0", bus.pready_o); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk); drive_setup(1'b1, 12'h0A0, 32'h33, 4'hF);
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if (bus.wr_o !== 1'b1) begin n_fail++; $display("FAIL rm_wr_pre: got %b exp 1", bus.wr_o); end
    @(negedge clk); rst = 1'b1; drive_idle(); bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.pwrite_i = 1'b1;
    #1;
    n_tests++; if ({bus.wr_o, bus.pready_o} !== 2'b00) begin n_fail++; $display("FAIL rm_wr_rst: got wr,pready=%b exp 00", {bus.wr_o, bus.pready_o}); end
    n_tests++; if ({bus.waddr_o, bus.prdata_o} !== 44'h0) begin n_fail++; $display("FAIL rm_clear: got %h exp 0", {bus.waddr_o, bus.prdata_o}); end
    @(negedge clk); rst = 1'b0; drive_idle();
    @(negedge clk); drive_setup(1'b0, 12'h010, 32'h0, 4'h0);
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if ({bus.rd_o, bus.raddr_o} !== {1'b1, 12'h010}) begin n_fail++; $display("FAIL rm_rd: got %h exp 1010", {bus.rd_o, bus.raddr_o}); end
    @(negedge clk); bus.read_valid_i = 1'b1; bus.rdata_i = 32'h5A5A_0001;
    @(negedge clk); bus.read_valid_i = 1'b0;
    n_tests++; if ({bus.pready_o, bus.pslverr_o} !== 2'b10) begin n_fail++; $display("FAIL rm_done: got pready,pslverr=%b exp 10", {bus.pready_o, bus.pslverr_o}); end
    n_tests++; if (bus.prdata_o !== 32'h5A5A_0001) begin n_fail++; $display("FAIL rm_prdata: got %h exp 5a5a0001", bus.prdata_o); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_abort;
    int pr_seen = 0;
    @(negedge clk); drive_setup(1'b0, 12'h030, 32'h0, 4'h0);
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if (bus.rd_o !== 1'b1) begin n_fail++; $display("FAIL ab_rd: got %b exp 1", bus.rd_o); end
    drive_idle();
    #1;
    n_tests++; if (bus.rd_o !== 1'b0) begin n_fail++; $display("FAIL ab_rd_drop: got %b exp 0", bus.rd_o); end
    repeat (4) begin
      @(negedge clk);
      if (bus.pready_o || bus.rd_ack_o) pr_seen++;
    end
    n_tests++; if (pr_seen !== 0) begin n_fail++; $display("FAIL ab_pready: got %0d cycles exp 0", pr_seen); end
    n_tests++; if (bus.prdata_o !== 32'h5A5A_0001) begin n_fail++; $display("FAIL ab_prdata: got %h exp 5a5a0001", bus.prdata_o); end
  endtask

  // Next setup is already on the bus during DONE; it must be captured one edge later, in IDLE.
  task automatic test_back_to_back;
    @(negedge clk); drive_setup(1'b1, 12'h044, 32'hA5A5_5A5A, 4'hC);
    @(negedge clk); bus.penable_i = 1'b1; bus.wr_ack_i = 1'b1;
    @(negedge clk); bus.wr_ack_i = 1'b0;
    n_tests++; if ({bus.pready_o, bus.pslverr_o} !== 2'b10) begin n_fail++; $display("FAIL bb_wr_done: got pready,pslverr=%b exp 10", {bus.pready_o, bus.pslverr_o}); end
    n_tests++; if ({bus.wdata_o, bus.wbyte_enable_o} !== {32'hA5A5_5A5A, 4'hC}) begin n_fail++; $display("FAIL bb_wdata: got %h exp a5a55a5ac", {bus.wdata_o, bus.wbyte_enable_o}); end
    drive_setup(1'b0, 12'h048, 32'h0, 4'h0);
    @(negedge clk);
    n_tests++; if ({bus.pready_o, bus.rd_o} !== 2'b00) begin n_fail++; $display("FAIL bb_gap: got pready,rd=%b exp 00", {bus.pready_o, bus.rd_o}); end
    n_tests++; if (bus.waddr_o !== 12'h044) begin n_fail++; $display("FAIL bb_ignore_setup: got %h exp 044", bus.waddr_o); end
    @(negedge clk); bus.penable_i = 1'b1;
    n_tests++; if ({bus.rd_o, bus.raddr_o} !== {1'b1, 12'h048}) begin n_fail++; $display("FAIL bb_rd: got %h exp 1048", {bus.rd_o, bus.raddr_o}); end
    bus.read_valid_i = 1'b1; bus.rdata_i = 32'hCAFE_F00D;
    @(negedge clk); bus.read_valid_i = 1'b0;
    n_tests++; if ({bus.pready_o, bus.rd_ack_o, bus.prdata_o} !== {2'b11, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL bb_rd_done: got %h exp 3cafef00d", {bus.pready_o, bus.rd_ack_o, bus.prdata_o}); end
    drive_idle();
    @(negedge clk);
    n_tests++; if (bus.pready_o !== 1'b0) begin n_fail++; $display("FAIL bb_idle: got %b exp 0", bus.pready_o); end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_write_ack();
    test_write_error();
    test_read();
    test_timeout();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
